// File: rtl/rv_pc_ctrl.sv
// rv_pc_ctrl - instruction-fetch PC controller with a one-entry fetch buffer.
// Keeps exactly one fetch outstanding, buffers the returned word for decode,
// and applies control-transfer redirects without ever changing a request's
// address while it waits for a grant.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   imem_req/addr/gnt           fetch request channel
//   imem_rvalid/rdata           fetch response channel
//   if_valid/instr/pc, id_ready buffered instruction handshake to decode
//   redirect_valid/pc           resolved control-transfer target
//   misalign_err                sticky misaligned-target flag
//
// Build option: RV_PC_CTRL_MISALIGN_TRAP_EN
//   defined   - a misaligned redirect target parks the controller in ERR
//               (no fetch, misalign_err=1) until an aligned redirect arrives
//   undefined - target bits [1:0] are forced to zero, misalign_err tied low
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | fetch request presented, waiting for grant
// WAIT  | fetch granted, waiting for response
// HOLD  | buffered instruction offered to decode
// ERR   | misaligned target, no fetch issued (trap build only)
module rv_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

`ifdef RV_PC_CTRL_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] fetch_pc;
  logic        kill;      // the outstanding response must be dropped
  logic        pend;      // redirect arrived while a request awaited grant
  logic [31:0] pend_pc;
  logic [31:0] tgt;
  state_t      redir_state; // next state when a redirect starts a new fetch
  state_t      kill_state;  // next state when a redirect orphans a granted fetch
  state_t      pend_state;  // next state when a pending redirect is granted

`ifdef RV_PC_CTRL_MISALIGN_TRAP_EN
  logic tgt_bad;
  logic pend_bad;

  always_comb begin
    tgt         = redirect_pc;
    tgt_bad     = |redirect_pc[1:0];
    redir_state = tgt_bad ? S_ERR : S_REQ;
    kill_state  = tgt_bad ? S_ERR : S_WAIT;
    pend_state  = pend_bad ? S_ERR : S_WAIT;
  end

  assign misalign_err = (state == S_ERR);
`else
  always_comb begin
    tgt         = redirect_pc & 32'hFFFF_FFFC;
    redir_state = S_REQ;
    kill_state  = S_WAIT;
    pend_state  = S_WAIT;
  end

  assign misalign_err = 1'b0;
`endif

  // A request is withheld while a response from before an ERR episode is
  // still in flight, so only one fetch is ever outstanding.
  assign imem_req  = (state == S_REQ) && !kill;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
      kill     <= 1'b0;
      pend     <= 1'b0;
      pend_pc  <= 32'h0;
`ifdef RV_PC_CTRL_MISALIGN_TRAP_EN
      pend_bad <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          fetch_pc <= RESET_PC;
        end
        S_REQ: begin
          if (kill) begin
            if (imem_rvalid) kill <= 1'b0;
            if (redirect_valid) begin
              fetch_pc <= tgt;
              state    <= redir_state;
            end
          end else if (imem_gnt) begin
            pend <= 1'b0;
            if (redirect_valid) begin
              fetch_pc <= tgt;
              kill     <= 1'b1;
              state    <= kill_state;
            end else if (pend) begin
              fetch_pc <= pend_pc;
              kill     <= 1'b1;
              state    <= pend_state;
            end else begin
              state <= S_WAIT;
            end
          end else if (redirect_valid) begin
            // address must stay put until granted; remember the target
            pend    <= 1'b1;
            pend_pc <= tgt;
`ifdef RV_PC_CTRL_MISALIGN_TRAP_EN
            pend_bad <= tgt_bad;
`endif
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= tgt;
            if (imem_rvalid) begin
              kill  <= 1'b0;
              state <= redir_state;
            end else begin
              kill  <= 1'b1;
              state <= kill_state;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= fetch_pc;
              if_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            if_valid <= 1'b0;
            fetch_pc <= tgt;
            state    <= redir_state;
          end else if (id_ready) begin
            if_valid <= 1'b0;
            fetch_pc <= if_pc + 32'd4;
            state    <= S_REQ;
          end
        end
`ifdef RV_PC_CTRL_MISALIGN_TRAP_EN
        S_ERR: begin
          if (imem_rvalid) kill <= 1'b0;
          if (redirect_valid && !tgt_bad) begin
            fetch_pc <= tgt;
            state    <= S_REQ;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
